// File: rtl/debug_regs_pkg.sv
// Word map, CTRL bit positions and helpers shared by the debug register bank.
package debug_regs_pkg;

  localparam int CTRL_W    = 0;
  localparam int CNT_W     = 1;
  localparam int SNAP_W    = 2;
  localparam int ID_W      = 3;
  localparam int CMP_W     = 4;
  localparam int RW_BASE_W = 8;

  localparam int CTRL_CNT_EN = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_SNAP   = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_OVF    = 8;
  localparam int CTRL_MATCH  = 9;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hD0B6_0001;

  typedef enum logic [2:0] {
    WORD_CTRL,
    WORD_CNT,
    WORD_SNAP,
    WORD_ID,
    WORD_CMP,
    WORD_RW,
    WORD_RO,
    WORD_NONE
  } word_kind_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dbg_cycle_counter.sv
// 32-bit cycle counter with snapshot, sticky wrap flag and sticky compare match.
// Match detection exists only when DEBUG_REGS_CMP_EN is defined.
module dbg_cycle_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cnt_en_i,
  input  logic        clr_i,
  input  logic        snap_i,
  input  logic        ovf_clr_i,
  input  logic        match_clr_i,
  input  logic [31:0] cmp_i,
  output logic [31:0] cnt_o,
  output logic [31:0] snap_o,
  output logic        ovf_o,
  output logic        match_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic        ovf_q, ovf_d;
  logic        match_q, match_d;
  logic        wrap;

  // A clear in the same cycle suppresses the increment, so it cannot wrap.
  assign wrap = cnt_en_i & ~clr_i & (cnt_q == 32'hFFFF_FFFF);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)         cnt_d = '0;
    else if (cnt_en_i) cnt_d = cnt_q + 32'd1;
    snap_d = snap_i ? cnt_q : snap_q;
    ovf_d  = wrap | (ovf_q & ~ovf_clr_i);
  end

`ifdef DEBUG_REGS_CMP_EN
  assign match_d = (cnt_en_i & (cnt_q == cmp_i)) | (match_q & ~match_clr_i);
`else
  logic unused_cmp;
  assign unused_cmp = ^{cmp_i, match_clr_i};
  assign match_d    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign snap_o  = snap_q;
  assign ovf_o   = ovf_q;
  assign match_o = match_q;

endmodule

// File: rtl/debug_regs_bank.sv
// Wishbone debug-register bank: control/counter words, ID, scratch registers and status samples.
// Defining DEBUG_REGS_CMP_EN adds the CMP register, MATCH flag and irq_o.
module debug_regs_bank
  import debug_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4100_0000,
  parameter int          ADDR_BITS = 5,
  parameter int          NUM_RW    = 4,
  parameter int          NUM_RO    = 2,
  parameter logic [31:0] ID_VALUE  = DEFAULT_ID_VALUE,
  localparam int         RO_SLOTS  = (NUM_RO > 0) ? NUM_RO : 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic [32*RO_SLOTS-1:0]  dbg_status_i,
  output logic [32*NUM_RW-1:0]    dbg_ctrl_o,
  output logic                    irq_o
);

  logic                   hit, req, wr_en, ctrl_wr;
  logic                   ack_q;
  logic [31:0]            dat_q;
  logic [31:0]            word_a, rw_idx, ro_idx;
  word_kind_e             kind;
  logic [32*RO_SLOTS-1:0] status_q;
  logic [32*NUM_RW-1:0]   rw_all;
  logic                   cnt_en_q, irq_en_q;
  logic [31:0]            cmp_val;
  logic [31:0]            cnt, snap;
  logic                   ovf, match;
  logic                   clr, snap_req, ovf_clr, match_clr;
  logic [31:0]            ctrl_rd, rdata;
  logic                   unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  assign hit    = (wbs_adr_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign req    = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr_en  = req & wbs_we_i;
  assign word_a = 32'(wbs_adr_i[ADDR_BITS+1:2]);
  // Below-range words wrap to huge indices, so a single upper-bound test suffices.
  assign rw_idx = word_a - 32'(RW_BASE_W);
  assign ro_idx = rw_idx - 32'(NUM_RW);

  always_comb begin
    kind = WORD_NONE;
    if (word_a == 32'(CTRL_W))      kind = WORD_CTRL;
    else if (word_a == 32'(CNT_W))  kind = WORD_CNT;
    else if (word_a == 32'(SNAP_W)) kind = WORD_SNAP;
    else if (word_a == 32'(ID_W))   kind = WORD_ID;
    else if (word_a == 32'(CMP_W))  kind = WORD_CMP;
    else if (rw_idx < 32'(NUM_RW))  kind = WORD_RW;
    else if (ro_idx < 32'(NUM_RO))  kind = WORD_RO;
  end

  assign ctrl_wr   = wr_en & (kind == WORD_CTRL);
  assign clr       = ctrl_wr & wbs_sel_i[0] & wbs_dat_i[CTRL_CLR];
  assign snap_req  = ctrl_wr & wbs_sel_i[0] & wbs_dat_i[CTRL_SNAP];
  assign ovf_clr   = ctrl_wr & wbs_sel_i[1] & wbs_dat_i[CTRL_OVF];
  assign match_clr = ctrl_wr & wbs_sel_i[1] & wbs_dat_i[CTRL_MATCH];

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      cnt_en_q <= 1'b0;
      irq_en_q <= 1'b0;
    end else if (ctrl_wr && wbs_sel_i[0]) begin
      cnt_en_q <= wbs_dat_i[CTRL_CNT_EN];
      irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
    end
  end

`ifdef DEBUG_REGS_CMP_EN
  logic [31:0] cmp_q;
  logic        irq_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      cmp_q <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr_en && kind == WORD_CMP) cmp_q <= byte_merge(cmp_q, wbs_dat_i, wbs_sel_i);
      irq_q <= match & irq_en_q;
    end
  end

  assign cmp_val = cmp_q;
  assign irq_o   = irq_q;
`else
  assign cmp_val = '0;
  assign irq_o   = 1'b0;
`endif

  dbg_cycle_counter u_cnt (
    .clk_i       (wb_clk_i),
    .rst_ni      (wb_rst_i),
    .cnt_en_i    (cnt_en_q),
    .clr_i       (clr),
    .snap_i      (snap_req),
    .ovf_clr_i   (ovf_clr),
    .match_clr_i (match_clr),
    .cmp_i       (cmp_val),
    .cnt_o       (cnt),
    .snap_o      (snap),
    .ovf_o       (ovf),
    .match_o     (match)
  );

  for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw
    logic [31:0] rw_q;
    logic        wr_sel;

    assign wr_sel = wr_en && (kind == WORD_RW) && (rw_idx == 32'(gi));

    always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i)   rw_q <= '0;
      else if (wr_sel) rw_q <= byte_merge(rw_q, wbs_dat_i, wbs_sel_i);
    end

    assign rw_all[32*gi +: 32] = rw_q;
  end

  assign dbg_ctrl_o = rw_all;

  // Sampled every cycle, so a read reports the value from one cycle before the ack edge.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) status_q <= '0;
    else           status_q <= dbg_status_i;
  end

  assign ctrl_rd = {22'b0, match, ovf, 4'b0, irq_en_q, 2'b0, cnt_en_q};

  always_comb begin
    rdata = '0;
    case (kind)
      WORD_CTRL: rdata = ctrl_rd;
      WORD_CNT:  rdata = cnt;
      WORD_SNAP: rdata = snap;
      WORD_ID:   rdata = ID_VALUE;
      WORD_CMP:  rdata = cmp_val;
      WORD_RW: begin
        for (int k = 0; k < NUM_RW; k++) begin
          if (rw_idx == 32'(k)) rdata = rw_all[32*k +: 32];
        end
      end
      WORD_RO: begin
        for (int j = 0; j < NUM_RO; j++) begin
          if (ro_idx == 32'(j)) rdata = status_q[32*j +: 32];
        end
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wbs_we_i) ? rdata : '0;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_debug_regs_bank.sv
// Scoreboard bench for debug_regs_bank: expected read data is queued at issue and checked at ack.
// Build with +define+DEBUG_REGS_CMP_EN to exercise the compare/IRQ path.
module tb_debug_regs_bank;

  localparam logic [31:0] BASE = 32'h4100_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]   sel = 4'h0;
  logic [31:0]  dat_w = '0, adr = '0;
  logic         ack;
  logic [31:0]  dat_r;
  logic [63:0]  status = '0;
  logic [127:0] ctrl_o;
  logic         irq;

  always #5 clk = ~clk;

  debug_regs_bank dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst_n),
    .wbs_stb_i    (stb),
    .wbs_cyc_i    (cyc),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_dat_i    (dat_w),
    .wbs_adr_i    (adr),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (dat_r),
    .dbg_status_i (status),
    .dbg_ctrl_o   (ctrl_o),
    .irq_o        (irq)
  );

  typedef struct {
    string       tag;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   last_lat = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rd, output bit acked);
    @(negedge clk);
    adr = a; we = w; sel = s; dat_w = d; cyc = 1'b1; stb = 1'b1;
    acked = 1'b0;
    rd = '0;
    last_lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        rd = dat_r;
        last_lat = i;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input string tag, input logic [31:0] a,
                         input logic [31:0] lo, input logic [31:0] hi);
    exp_t        e;
    logic [31:0] rd;
    bit          acked;
    e.tag = tag; e.lo = lo; e.hi = hi;
    sb_q.push_back(e);
    wb_xfer(a, 1'b0, 4'hF, 32'h0, rd, acked);
    e = sb_q.pop_front();
    if (!acked)             check_val({e.tag, "_ack"}, 32'(acked), 32'd1);
    else if (e.lo == e.hi)  check_val(e.tag, rd, e.lo);
    else                    check_val({e.tag, "_range"}, 32'(rd >= e.lo && rd <= e.hi), 32'd1);
  endtask

  task automatic wb_write(input string tag, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rd;
    bit          acked;
    wb_xfer(a, 1'b1, s, d, rd, acked);
    check_val({tag, "_ack"}, 32'(acked), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    bit          acked;
    int          n;
    bit          seen;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_dat", dat_r, 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_ctrl_o", 32'(|ctrl_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    wb_read("id", BASE + 32'h0C, 32'hD0B6_0001, 32'hD0B6_0001);
    check_val("id_latency", 32'(last_lat), 32'd0);
    wb_read("id_lowbits", BASE + 32'h0F, 32'hD0B6_0001, 32'hD0B6_0001);
    wb_read("reserved", BASE + 32'h14, 32'h0, 32'h0);

    wb_write("rw0_w1", BASE + 32'h20, 4'b0101, 32'hA5A5_A5A5);
    wb_read("rw0_r1", BASE + 32'h20, 32'h00A5_00A5, 32'h00A5_00A5);
    check_val("rw0_ctrl_o", ctrl_o[31:0], 32'h00A5_00A5);
    wb_write("rw0_w2", BASE + 32'h20, 4'b1010, 32'h5A5A_5A5A);
    wb_read("rw0_r2", BASE + 32'h20, 32'h5AA5_5AA5, 32'h5AA5_5AA5);
    wb_write("rw3_w", BASE + 32'h2C, 4'hF, 32'h1234_5678);
    wb_read("rw3_r", BASE + 32'h2C, 32'h1234_5678, 32'h1234_5678);
    check_val("rw3_ctrl_o", ctrl_o[127:96], 32'h1234_5678);

    wb_xfer(BASE + 32'h100, 1'b1, 4'hF, 32'hFFFF_FFFF, rd, acked);
    check_val("miss_no_ack", 32'(acked), 32'd0);

    status = {32'h5555_AAAA, 32'hCAFE_F00D};
    repeat (2) @(posedge clk);
    wb_read("ro0", BASE + 32'h30, 32'hCAFE_F00D, 32'hCAFE_F00D);
    wb_read("ro1", BASE + 32'h34, 32'h5555_AAAA, 32'h5555_AAAA);
    wb_write("ro0_w", BASE + 32'h30, 4'hF, 32'hFFFF_FFFF);
    wb_read("ro0_after_w", BASE + 32'h30, 32'hCAFE_F00D, 32'hCAFE_F00D);
    wb_write("id_w", BASE + 32'h0C, 4'hF, 32'h0);
    wb_read("id_after_w", BASE + 32'h0C, 32'hD0B6_0001, 32'hD0B6_0001);

    wb_write("ctrl_en", BASE, 4'h1, 32'h1);
    repeat (100) @(posedge clk);
    wb_write("ctrl_snap", BASE, 4'h1, 32'h5);
    wb_read("snap_100", BASE + 32'h08, 32'd98, 32'd102);
    wb_read("ctrl_selfclr", BASE, 32'h1, 32'h1);
    wb_read("cnt_running", BASE + 32'h04, 32'd101, 32'd200);

    repeat (20) @(posedge clk);
    wb_write("ctrl_snap_clr", BASE, 4'h1, 32'h7);
    wb_read("snap_preclear", BASE + 32'h08, 32'd110, 32'd400);
    wb_read("cnt_after_clr", BASE + 32'h04, 32'd0, 32'd5);

    wb_write("ctrl_stop_clr", BASE, 4'h1, 32'h2);
    wb_read("cnt_zero", BASE + 32'h04, 32'h0, 32'h0);
    @(negedge clk);
    force dut.u_cnt.cnt_q = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.u_cnt.cnt_q;
    wb_read("cnt_preload", BASE + 32'h04, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
    wb_write("ctrl_en2", BASE, 4'h1, 32'h1);
    repeat (3) @(posedge clk);
    wb_read("ovf_set", BASE, 32'h101, 32'h101);
    wb_read("cnt_wrapped", BASE + 32'h04, 32'd1, 32'd10);
    wb_write("ovf_clr_byte0", BASE, 4'b0001, 32'h101);
    wb_read("ovf_kept", BASE, 32'h101, 32'h101);
    wb_write("ovf_clr_byte1", BASE, 4'b0010, 32'h100);
    wb_read("ovf_cleared", BASE, 32'h001, 32'h001);

`ifdef DEBUG_REGS_CMP_EN
    wb_write("cmp_stop_clr", BASE, 4'h1, 32'h2);
    wb_write("cmp_w", BASE + 32'h10, 4'hF, 32'd50);
    wb_read("cmp_r", BASE + 32'h10, 32'd50, 32'd50);
    wb_write("match_preclr", BASE, 4'b0010, 32'h200);
    wb_write("ctrl_irq_en", BASE, 4'h1, 32'h9);
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (irq) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("irq_rise", 32'(seen), 32'd1);
    check_val("irq_delay", 32'(n >= 45 && n <= 60), 32'd1);
    wb_read("match_set", BASE, 32'h209, 32'h209);
    wb_write("match_w1c", BASE, 4'b0011, 32'h209);
    @(posedge clk); #1;
    check_val("irq_cleared", 32'(irq), 32'd0);
    wb_read("match_cleared", BASE, 32'h009, 32'h009);
`else
    wb_write("cmp_w", BASE + 32'h10, 4'hF, 32'd50);
    wb_read("cmp_reads_zero", BASE + 32'h10, 32'h0, 32'h0);
    wb_write("ctrl_irq_en", BASE, 4'hF, 32'h209);
    wb_read("match_bit_zero", BASE, 32'h009, 32'h009);
    check_val("irq_tied_low", 32'(irq), 32'd0);
`endif

    @(negedge clk);
    adr = BASE + 32'h24; we = 1'b1; sel = 4'hF; dat_w = 32'hDEAD_BEEF;
    cyc = 1'b1; stb = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("rst_abort_ack", 32'(ack), 32'd0);
    check_val("rst_abort_rw1", ctrl_o[63:32], 32'h0);
    check_val("rst_abort_rw0", ctrl_o[31:0], 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_read("ctrl_after_rst", BASE, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
